// File: rtl/uart_pkg.sv
// ============================================================
// uart_pkg : shared UART link defaults and rx state encoding
// Rev 1.0
// ============================================================
`default_nettype none

package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int SCALE_DEF      = 1250;
  localparam int SCALE_BITS_DEF = 11;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_sync2.sv
// ============================================================
// uart_sync2 : two-flop synchroniser, async reset to idle-high
// Rev 1.0
// ============================================================
`default_nettype none

module uart_sync2 (
  input  logic sysclk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================
// uart_rx : 8N1-style UART receiver with centre sampling and framing-error flag
// Rev 1.0
// ============================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SCALE      = SCALE_DEF,
  parameter int SCALE_BITS = SCALE_BITS_DEF
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_data_valid,
  output logic                  rx_frame_err,
  output logic                  rx_busy
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [SCALE_BITS-1:0] HALF_M1  = SCALE_BITS'(SCALE / 2 - 1);
  localparam logic [SCALE_BITS-1:0] FULL_M1  = SCALE_BITS'(SCALE - 1);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  logic rx_s;

  uart_sync2 u_sync (
    .sysclk (sysclk),
    .rst    (rst),
    .d      (rx),
    .q      (rx_s)
  );

  rx_state_e               state_q, state_d;
  logic [SCALE_BITS-1:0]   scale_cnt_q, scale_cnt_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    scale_cnt_d = scale_cnt_q + SCALE_BITS'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    busy_d      = busy_q;
    case (state_q)
      RX_IDLE: begin
        scale_cnt_d = '0;
        bit_cnt_d   = '0;
        if (!rx_s) begin
          state_d = RX_START;
          busy_d  = 1'b1;
        end
      end
      RX_START: begin
        // Half a bit in: a line back high means the falling edge was a glitch
        if (scale_cnt_q == HALF_M1) begin
          scale_cnt_d = '0;
          bit_cnt_d   = '0;
          if (rx_s) begin
            state_d = RX_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (scale_cnt_q == FULL_M1) begin
          scale_cnt_d = '0;
          shift_d     = {rx_s, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d   = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (scale_cnt_q == FULL_M1) begin
          scale_cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = RX_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        scale_cnt_d = '0;
        bit_cnt_d   = '0;
        if (rx_s) begin
          busy_d  = 1'b0;
          state_d = RX_IDLE;
        end
      end
      default: begin
        scale_cnt_d = '0;
        bit_cnt_d   = '0;
        busy_d      = 1'b0;
        state_d     = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      scale_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      scale_cnt_q <= scale_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
  assign rx_frame_err  = err_q;
  assign rx_busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================
// tb_uart_rx : directed frame vectors and corner sequences for uart_rx
// Rev 1.0
// ============================================================
`default_nettype none

module tb_uart_rx;

  localparam int DW = 8;
  localparam int SC = 16;
  localparam int SB = 5;
  localparam int LATENCY = (DW + 1) * SC + SC / 2 + 2;

  logic          sysclk = 1'b0;
  logic          rst    = 1'b1;
  logic          rx     = 1'b1;
  logic [DW-1:0] rx_data;
  logic          rx_data_valid;
  logic          rx_frame_err;
  logic          rx_busy;

  always #5 sysclk = ~sysclk;

  uart_rx #(.DATA_WIDTH(DW), .SCALE(SC), .SCALE_BITS(SB)) dut (
    .sysclk        (sysclk),
    .rst           (rst),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_frame_err  (rx_frame_err),
    .rx_busy       (rx_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;
  int last_valid_cyc = 0;

  always @(posedge sysclk) cyc++;

  always @(negedge sysclk) begin
    if (rx_data_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (rx_frame_err) err_cnt++;
    if (rx_data_valid && rx_frame_err) overlap_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Serial frame, LSB first; rx is left at 'tail' after the stop bit
  task automatic send_frame(input logic [DW-1:0] d, input logic stop, input logic tail);
    rx = 1'b0;
    repeat (SC) @(negedge sysclk);
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      repeat (SC) @(negedge sysclk);
    end
    rx = stop;
    repeat (SC) @(negedge sysclk);
    rx = tail;
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          stop;
    int            gap_bits;
    int            exp_valid;
    int            exp_err;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int v0, e0, fall_cyc, lat, waited;
    logic [DW-1:0] prev;

    vecs[0] = '{8'hA5, 1'b1, 2, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 0, 1, 0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b1, 2, 1, 0, 8'h3C};
    vecs[4] = '{8'h81, 1'b0, 2, 0, 1, 8'h3C};
    vecs[5] = '{8'h5A, 1'b1, 0, 1, 0, 8'h5A};
    vecs[6] = '{8'hC3, 1'b1, 2, 1, 0, 8'hC3};

    #12;
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_valid", int'(rx_data_valid), 0);
    check("reset_err", int'(rx_frame_err), 0);
    check("reset_busy", int'(rx_busy), 0);
    @(negedge sysclk);
    rst = 1'b0;
    repeat (4) @(negedge sysclk);

    for (int k = 0; k < 7; k++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      send_frame(vecs[k].data, vecs[k].stop, 1'b1);
      #1;
      check($sformatf("vec%0d_valid_pulses", k), valid_cnt - v0, vecs[k].exp_valid);
      check($sformatf("vec%0d_err_pulses", k), err_cnt - e0, vecs[k].exp_err);
      check($sformatf("vec%0d_rx_data", k), int'(rx_data), int'(vecs[k].exp_data));
      if (vecs[k].stop) check($sformatf("vec%0d_busy_low", k), int'(rx_busy), 0);
      repeat (vecs[k].gap_bits * SC) @(negedge sysclk);
    end

    // Latency from rx falling edge to valid pulse
    fall_cyc = cyc;
    v0 = valid_cnt;
    send_frame(8'hA5, 1'b1, 1'b1);
    #1;
    lat = last_valid_cyc - fall_cyc;
    check("latency_pulses", valid_cnt - v0, 1);
    check("latency_in_window", int'(lat >= LATENCY - 1 && lat <= LATENCY + 1), 1);
    repeat (2 * SC) @(negedge sysclk);

    // Short low glitch must be rejected
    v0 = valid_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    repeat (5) @(negedge sysclk);
    rx = 1'b1;
    #1;
    check("glitch_busy_seen", int'(rx_busy), 1);
    repeat (2 * SC) @(negedge sysclk);
    #1;
    check("glitch_busy_low", int'(rx_busy), 0);
    check("glitch_no_valid", valid_cnt - v0, 0);
    check("glitch_no_err", err_cnt - e0, 0);
    send_frame(8'h5A, 1'b1, 1'b1);
    #1;
    check("after_glitch_data", int'(rx_data), 8'h5A);
    check("after_glitch_valid", valid_cnt - v0, 1);
    repeat (2 * SC) @(negedge sysclk);

    // Stop bit low, line then held low: one error, sits in BREAK
    prev = rx_data;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'h81, 1'b0, 1'b0);
    repeat (3 * SC) @(negedge sysclk);
    #1;
    check("break_one_err", err_cnt - e0, 1);
    check("break_no_valid", valid_cnt - v0, 0);
    check("break_data_kept", int'(rx_data), int'(prev));
    check("break_busy_high", int'(rx_busy), 1);
    rx = 1'b1;
    waited = 0;
    while (rx_busy && waited < 10) begin
      @(negedge sysclk);
      waited++;
    end
    check("break_exit_busy_low", int'(rx_busy), 0);
    repeat (SC) @(negedge sysclk);
    send_frame(8'h42, 1'b1, 1'b1);
    #1;
    check("after_break_data", int'(rx_data), 8'h42);
    check("after_break_valid", valid_cnt - v0, 1);
    repeat (2 * SC) @(negedge sysclk);

    // Reset in the middle of the data bits of 0x66
    v0 = valid_cnt;
    rx = 1'b0;
    repeat (SC) @(negedge sysclk);
    for (int i = 0; i < 3; i++) begin
      rx = (8'h66 >> i) & 1;
      repeat (SC) @(negedge sysclk);
    end
    check("midframe_busy_high", int'(rx_busy), 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_rx_data", int'(rx_data), 0);
    check("midrst_busy", int'(rx_busy), 0);
    check("midrst_valid", int'(rx_data_valid), 0);
    check("midrst_err", int'(rx_frame_err), 0);
    rx = 1'b1;
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    repeat (2 * SC) @(negedge sysclk);
    check("midrst_no_strobe", valid_cnt - v0, 0);
    send_frame(8'h99, 1'b1, 1'b1);
    #1;
    check("after_rst_data", int'(rx_data), 8'h99);
    check("after_rst_valid", valid_cnt - v0, 1);
    repeat (SC) @(negedge sysclk);

    check("valid_err_never_together", overlap_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
